// File: rtl/threshold_trigger_pkg.sv
// threshold_trigger_pkg: shared state encoding and sign-aware threshold compares
package threshold_trigger_pkg;

    typedef enum logic [1:0] {S_LOW, S_RISING, S_HIGH, S_FALLING} trig_state_t;

    // Flipping the sign bit maps two's complement onto offset binary, so one unsigned compare serves both modes
    function automatic logic cmp_ge(input logic [63:0] a, input logic [63:0] b, input int w, input logic sgn);
        logic [63:0] m;
        m = sgn ? (64'd1 << (w - 1)) : 64'd0;
        return (a ^ m) >= (b ^ m);
    endfunction

    function automatic logic cmp_le(input logic [63:0] a, input logic [63:0] b, input int w, input logic sgn);
        return cmp_ge(b, a, w, sgn);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter whose clear is applied before a same-cycle increment
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!nrst)
            cnt <= '0;
        else if (clr)
            cnt <= W'(inc);
        else if (inc && !(&cnt))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/threshold_trigger.sv
// threshold_trigger: hysteresis comparator with persistence filter, hold-off timer and rise counter
module threshold_trigger
    import threshold_trigger_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SIGNED    = 0,
    parameter int PERSIST   = 3,
    parameter int PERSIST_W = $clog2(PERSIST + 1),
    parameter int HOLDOFF   = 4,
    parameter int HOLDOFF_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ena,
    input  logic [DATA_W-1:0] id,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    input  logic              cnt_clr,
    output logic              level,
    output logic              rise,
    output logic              fall,
    output logic [CNT_W-1:0]  event_cnt
);

    localparam logic [PERSIST_W-1:0] P_LAST = PERSIST_W'(PERSIST - 1);
    localparam logic [HOLDOFF_W-1:0] H_INIT = HOLDOFF_W'(HOLDOFF);

    trig_state_t          state, state_n;
    logic [PERSIST_W-1:0] pcnt, pcnt_n;
    logic [HOLDOFF_W-1:0] hcnt, hcnt_n;
    logic                 rise_n, fall_n, above, below;

    assign above = cmp_ge(64'(id), 64'(thr_hi), DATA_W, SIGNED != 0);
    assign below = cmp_le(64'(id), 64'(thr_lo), DATA_W, SIGNED != 0);
    assign level = (state == S_HIGH) || (state == S_FALLING);

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        hcnt_n  = hcnt;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        if (ena) begin
            case (state)
                S_LOW: begin
                    if (hcnt != '0) begin
                        hcnt_n = hcnt - HOLDOFF_W'(1);
                    end else if (above && PERSIST == 1) begin
                        state_n = S_HIGH;
                        rise_n  = 1'b1;
                        hcnt_n  = H_INIT;
                    end else if (above) begin
                        state_n = S_RISING;
                        pcnt_n  = PERSIST_W'(1);
                    end
                end
                S_RISING: begin
                    if (above && pcnt == P_LAST) begin
                        state_n = S_HIGH;
                        pcnt_n  = '0;
                        rise_n  = 1'b1;
                        hcnt_n  = H_INIT;
                    end else if (above) begin
                        pcnt_n = pcnt + PERSIST_W'(1);
                    end else begin
                        state_n = S_LOW;
                        pcnt_n  = '0;
                    end
                end
                S_HIGH: begin
                    if (hcnt != '0) begin
                        hcnt_n = hcnt - HOLDOFF_W'(1);
                    end else if (below && PERSIST == 1) begin
                        state_n = S_LOW;
                        fall_n  = 1'b1;
                        hcnt_n  = H_INIT;
                    end else if (below) begin
                        state_n = S_FALLING;
                        pcnt_n  = PERSIST_W'(1);
                    end
                end
                default: begin
                    if (below && pcnt == P_LAST) begin
                        state_n = S_LOW;
                        pcnt_n  = '0;
                        fall_n  = 1'b1;
                        hcnt_n  = H_INIT;
                    end else if (below) begin
                        pcnt_n = pcnt + PERSIST_W'(1);
                    end else begin
                        state_n = S_HIGH;
                        pcnt_n  = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= S_LOW;
            pcnt  <= '0;
            hcnt  <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            pcnt  <= pcnt_n;
            hcnt  <= hcnt_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    sat_counter #(.W(CNT_W)) u_event_cnt (
        .clk  (clk),
        .nrst (nrst),
        .inc  (rise_n),
        .clr  (cnt_clr),
        .cnt  (event_cnt)
    );

endmodule

// File: tb/tb_threshold_trigger.sv
// tb_threshold_trigger: vector table, corner sequences and random run against a sample-level model
module tb_threshold_trigger;

    localparam int P = 3;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        nrst, ena, cnt_clr;
    logic [15:0] id, thr_hi, thr_lo;
    logic        level, rise, fall, level2, rise2, fall2;
    logic [15:0] event_cnt;
    logic [1:0]  event_cnt2;

    always #5 clk = ~clk;

    threshold_trigger #(.DATA_W(16), .SIGNED(0), .PERSIST(P), .HOLDOFF(H), .CNT_W(16)) dut (
        .clk(clk), .nrst(nrst), .ena(ena), .id(id), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .cnt_clr(cnt_clr), .level(level), .rise(rise), .fall(fall), .event_cnt(event_cnt)
    );

    threshold_trigger #(.DATA_W(16), .SIGNED(0), .PERSIST(P), .HOLDOFF(H), .CNT_W(2)) dut2 (
        .clk(clk), .nrst(nrst), .ena(ena), .id(id), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .cnt_clr(cnt_clr), .level(level2), .rise(rise2), .fall(fall2), .event_cnt(event_cnt2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Sample-level model: output level, current qualifying streak, samples left to ignore
    int m_lvl = 0, m_streak = 0, m_hold = 0, m_c16 = 0, m_c2 = 0, m_r = 0, m_f = 0;

    typedef struct {
        logic        n, e, c;
        logic [15:0] v;
        logic        lv, r, f;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic n, logic e, logic [15:0] v, logic c,
                                logic lv, logic r, logic f, logic [15:0] cnt);
        vec_t t;
        t.n = n; t.e = e; t.v = v; t.c = c; t.lv = lv; t.r = r; t.f = f; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_update();
        int q;
        if (!nrst) begin
            m_lvl = 0; m_streak = 0; m_hold = 0; m_c16 = 0; m_c2 = 0; m_r = 0; m_f = 0;
        end else begin
            m_r = 0;
            m_f = 0;
            if (ena) begin
                if (m_hold > 0) begin
                    m_hold--;
                end else begin
                    q = m_lvl ? (id <= thr_lo) : (id >= thr_hi);
                    m_streak = q ? m_streak + 1 : 0;
                    if (m_streak == P) begin
                        m_lvl = 1 - m_lvl;
                        m_streak = 0;
                        m_hold = H;
                        m_r = m_lvl;
                        m_f = 1 - m_lvl;
                    end
                end
            end
            if (cnt_clr) begin
                m_c16 = 0;
                m_c2 = 0;
            end
            if (m_r != 0) begin
                m_c16 = (m_c16 < 65535) ? m_c16 + 1 : m_c16;
                m_c2 = (m_c2 < 3) ? m_c2 + 1 : m_c2;
            end
        end
    endtask

    task automatic step(input logic n, input logic e, input logic [15:0] v, input logic c);
        nrst = n; ena = e; id = v; cnt_clr = c;
        @(posedge clk);
        model_update();
        #1;
        chk("level", level, m_lvl);
        chk("rise", rise, m_r);
        chk("fall", fall, m_f);
        chk("cnt16", event_cnt, m_c16);
        chk("cnt2", event_cnt2, m_c2);
        chk("level2", level2, m_lvl);
    endtask

    initial begin
        int exp2[5] = '{1, 2, 3, 3, 3};
        nrst = 1'b0; ena = 1'b0; id = '0; cnt_clr = 1'b0;
        thr_hi = 16'd100; thr_lo = 16'd50;

        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 1, 120, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 120, 0, 1, 1, 0, 1));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 1, 40, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 40, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 120, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 120, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 120, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 120, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 90, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 120, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 120, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 120, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 120, 0, 1, 0, 0, 1));

        foreach (tbl[i]) begin
            step(tbl[i].n, tbl[i].e, tbl[i].v, tbl[i].c);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lv);
            chk($sformatf("tbl%0d_rise", i), rise, tbl[i].r);
            chk($sformatf("tbl%0d_fall", i), fall, tbl[i].f);
            chk($sformatf("tbl%0d_cnt", i), event_cnt, tbl[i].cnt);
        end

        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 120, 0);
            chk("gap_rise", rise, int'(k == 2));
            for (int g = 0; g < 5; g++) begin
                step(1, 0, 120, 0);
                chk("gap_idle_rise", rise, 0);
                chk("gap_idle_level", level, int'(k == 2));
            end
        end

        step(0, 0, 0, 0);
        step(1, 1, 120, 0);
        step(1, 1, 120, 0);
        step(0, 1, 120, 0);
        chk("rstmid_level", level, 0);
        chk("rstmid_rise", rise, 0);
        step(1, 1, 120, 0);
        step(1, 1, 120, 0);
        chk("rstmid_norise", rise, 0);
        step(1, 1, 120, 0);
        chk("rstmid_rise3", rise, 1);

        step(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < ((k == 0) ? 3 : 7); j++) step(1, 1, 120, 0);
            chk("sat_rise", rise2, 1);
            chk("sat_cnt2", event_cnt2, exp2[k]);
            chk("sat_cnt16", event_cnt, k + 1);
            for (int j = 0; j < 7; j++) step(1, 1, 40, 0);
            chk("sat_fall", fall, 1);
        end
        for (int j = 0; j < 6; j++) step(1, 1, 120, 0);
        step(1, 1, 120, 1);
        chk("clr_rise_rise", rise, 1);
        chk("clr_rise_cnt2", event_cnt2, 1);
        chk("clr_rise_cnt16", event_cnt, 1);
        step(1, 0, 120, 1);
        chk("clr_only_cnt2", event_cnt2, 0);
        chk("clr_only_cnt16", event_cnt, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                thr_hi = 16'($urandom_range(60, 130));
                thr_lo = 16'($urandom_range(20, 110));
            end
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                 16'($urandom_range(20, 140)), $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/threshold_trigger.md
Name: threshold_trigger

Overview:
Hysteresis comparator with persistence filter and hold-off timer. Sits directly downstream of the moving-average stage and consumes its averaged output stream. Converts the smoothed sample stream into a debounced level, single-cycle rise/fall strobes, and a saturating event count for status registers.

Parameters:
DATA_W, 32, sample width; must match upstream averager.
SIGNED, 0, 1 = signed compare of id and thresholds; 0 = unsigned.
PERSIST, 3, consecutive qualifying samples needed to switch level; must be 1 or greater.
PERSIST_W, $clog2(PERSIST+1), persistence counter width; derived, not overridden.
HOLDOFF, 4, samples ignored after any level change; 0 disables hold-off.
HOLDOFF_W, $clog2(HOLDOFF+1), hold-off counter width; derived.
CNT_W, 16, event counter width.

Ports:
clk  in  1  clock
nrst  in  1  reset; synchronous, active-low
ena  in  1  sample valid; same qualifier as the upstream averager
id  in  DATA_W  averaged sample
thr_hi  in  DATA_W  upper threshold; qualifies when id >= thr_hi
thr_lo  in  DATA_W  lower threshold; qualifies when id <= thr_lo
cnt_clr  in  1  synchronous clear of event_cnt
level  out  1  debounced level, registered
rise  out  1  one-clk strobe on low-to-high change
fall  out  1  one-clk strobe on high-to-low change
event_cnt  out  CNT_W  number of rises; saturates at all-ones

Behaviour:
- Reset (nrst=0 at posedge):
  - state=S_LOW, level=0, rise=0, fall=0, event_cnt=0.
  - Persistence counter = 0, hold-off counter = 0 (armed immediately).
  - Reset overrides everything, including mid-pend states.
- Sample processing occurs only on posedges with ena=1. With ena=0, state and all counters hold and rise/fall are driven 0.
- Definitions: above = (id >= thr_hi); below = (id <= thr_lo). SIGNED selects $signed compare.
- Thresholds are sampled live each ena cycle. A threshold change takes effect on the next sample and does not clear a pending count.
- States (shared enum):
  - S_LOW:
    - If holdoff != 0: decrement holdoff; sample ignored.
    - Else if above and PERSIST==1: go to S_HIGH; do the rise actions.
    - Else if above: go to S_RISING, pcnt=1.
  - S_RISING:
    - If above and pcnt+1==PERSIST: go to S_HIGH, pcnt=0; do the rise actions.
    - Else if above: pcnt++.
    - Else (not above): go to S_LOW, pcnt=0.
  - S_HIGH, S_FALLING: mirror of S_LOW and S_RISING, using below; the transition into S_LOW performs the fall actions.
- Rise actions: rise=1, level=1, holdoff=HOLDOFF, event_cnt+1.
- Fall actions: fall=1, level=0, holdoff=HOLDOFF.
- A sample evaluated with holdoff != 0 only decrements the counter, so HOLDOFF samples are swallowed after each change.
- level = 1 in S_HIGH and S_FALLING; 0 otherwise.
- Latency: sample accepted at edge k; level, rise and fall are valid from edge k through k+1. Strobes last exactly one clk even if ena stays high.
- Inverted thresholds (thr_lo > thr_hi) are legal: only one comparator is consulted per state, so there is no conflict. Output may chatter; that is the user's responsibility.
- event_cnt:
  - Saturates at 2^CNT_W-1.
  - cnt_clr alone: next value 0.
  - cnt_clr with a rise in the same cycle: next value 1 (clear applied first, then increment).
  - cnt_clr is honoured regardless of ena.
- Persistence is counted in samples, not clocks. ena gaps never break a pending sequence.

Decomposition:
- Package threshold_trigger_pkg holds:
  - typedef enum logic [1:0] {S_LOW, S_RISING, S_HIGH, S_FALLING} trig_state_t.
  - A function for signed/unsigned >= and <= compares.
- One natural sub-module: sat_counter (parametrised CNT_W, inc, clr, with the clear-then-increment rule). It is reused for event_cnt and available to other status blocks.
- The FSM, persistence counter and hold-off counter live in the top module.

Test Plan:
All scenarios use DATA_W=16, PERSIST=3, HOLDOFF=4, thr_hi=100, thr_lo=50, unless noted.
1. Reset, then id=120 on 3 consecutive ena cycles -> rise=1 for one clk after the 3rd sample, level=1, event_cnt=1; no rise after samples 1–2.
2. id sequence 120,120,90,120,120,120 (ena=1) -> no rise until the 6th sample; the 90 resets pending; level=0 until then.
3. After scenario 1, id=40 continuously -> samples 1–4 swallowed by hold-off, fall=1 after the 7th sample, level=0.
4. id=120 samples separated by 5 clk of ena=0 each -> rise after the 3rd sample; strobes 0 during gaps; state held.
5. CNT_W=2, five qualified rise/fall cycles -> event_cnt 1,2,3,3,3; then cnt_clr coincident with a rise -> event_cnt=1.
6. nrst=0 for one clk while in S_RISING (pcnt=2) -> level=0, rise=0; next id=120 needs 3 fresh samples before rise.
